// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write-port signals of the boot loader.
// Handshake: a byte transfers on a rising clk edge where in_valid_i and
// in_ready_o are both high; the source holds in_data_i stable while
// in_valid_i is high and in_ready_o is low, and in_ready_o never depends
// on in_valid_i. The write port has no handshake: w_en_o is a one-cycle
// strobe and w_addr_o/w_data_o/w_sel_o are zero whenever w_en_o is low.
interface rom_loader_if;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_ready_o;
  logic        w_en_o;
  logic [31:0] w_addr_o;
  logic [31:0] w_data_o;
  logic [3:0]  w_sel_o;

  // Loader side: consumes the stream, drives the ROM write port.
  modport master (
    input  in_valid_i, in_data_i,
    output in_ready_o, w_en_o, w_addr_o, w_data_o, w_sel_o
  );

  // Environment side: produces the stream, observes the ROM write port.
  modport slave (
    output in_valid_i, in_data_i,
    input  in_ready_o, w_en_o, w_addr_o, w_data_o, w_sel_o
  );
endinterface

// File: rtl/rom_loader.sv
// Boot-time ROM loader: takes a 4-byte little-endian length header followed
// by the payload, packs payload bytes little-endian into 32-bit words and
// issues one byte-masked write per word starting at BASE_ADDR.
module rom_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ROM_DEPTH   = 16384,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  rom_loader_if.master        bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Idle count at which the next idle edge declares a timeout.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] DEPTH   = 32'(ROM_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] len_q;
  logic [1:0]  hdr_cnt_q;
  logic [31:0] byte_cnt_q;
  logic [31:0] word_idx_q;
  logic [31:0] idle_cnt_q;
  logic [31:0] buf_q;
  logic        ovf_q;

  logic        in_ready;
  logic        acc;
  logic [1:0]  lane;
  logic        last_byte;
  logic        word_full;
  logic        in_rom;
  logic        timeout;
  logic [31:0] len_full;
  logic [31:0] merged;
  logic [3:0]  sel_mask;

  assign in_ready  = (state_q == S_LEN) || (state_q == S_DATA);
  assign acc       = bus.in_valid_i & in_ready;
  assign lane      = byte_cnt_q[1:0];
  assign last_byte = (byte_cnt_q + 32'd1) == len_q;
  assign word_full = (lane == 2'd3);
  assign in_rom    = word_idx_q < DEPTH;
  assign timeout   = idle_cnt_q >= TO_LAST;
  assign len_full  = {bus.in_data_i, len_q[23:0]};

  // Current word with the incoming byte dropped into its lane; lanes not yet
  // filled stay zero because the buffer is cleared after every word.
  always_comb begin
    merged = buf_q;
    merged[{lane, 3'b000} +: 8] = bus.in_data_i;
  end

  // Byte enables cover lanes 0..lane of the word being closed.
  always_comb begin
    sel_mask = 4'b0000;
    case (lane)
      2'd0: sel_mask = 4'b0001;
      2'd1: sel_mask = 4'b0011;
      2'd2: sel_mask = 4'b0111;
      2'd3: sel_mask = 4'b1111;
      default: sel_mask = 4'b0000;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an idle timeout only fires on an edge without a byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) state_d = S_LEN;
      end
      S_LEN: begin
        if (acc) begin
          if (hdr_cnt_q == 2'd3) state_d = (len_full == 32'd0) ? S_DONE : S_DATA;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (acc) begin
          if (last_byte) state_d = word_full ? S_DONE : S_FLUSH;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Header capture, byte packing, idle counting and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q          <= '0;
      hdr_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      word_idx_q     <= '0;
      idle_cnt_q     <= '0;
      buf_q          <= '0;
      ovf_q          <= 1'b0;
      bus.w_en_o     <= 1'b0;
      bus.w_addr_o   <= '0;
      bus.w_data_o   <= '0;
      bus.w_sel_o    <= '0;
    end else begin
      bus.w_en_o   <= 1'b0;
      bus.w_addr_o <= '0;
      bus.w_data_o <= '0;
      bus.w_sel_o  <= '0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            len_q      <= '0;
            hdr_cnt_q  <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            idle_cnt_q <= '0;
            buf_q      <= '0;
            ovf_q      <= 1'b0;
          end
        end
        S_LEN: begin
          if (acc) begin
            len_q[{hdr_cnt_q, 3'b000} +: 8] <= bus.in_data_i;
            hdr_cnt_q  <= hdr_cnt_q + 2'd1;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
          end
        end
        S_DATA: begin
          if (acc) begin
            idle_cnt_q <= '0;
            byte_cnt_q <= byte_cnt_q + 32'd1;
            if (word_full || last_byte) begin
              // Word closes here: full lane 3, or the short tail of the payload.
              buf_q      <= '0;
              word_idx_q <= word_idx_q + 32'd1;
              if (in_rom) begin
                bus.w_en_o   <= 1'b1;
                bus.w_addr_o <= BASE_ADDR + {word_idx_q[29:0], 2'b00};
                bus.w_data_o <= merged;
                bus.w_sel_o  <= sel_mask;
              end else begin
                ovf_q <= 1'b1;
              end
            end else begin
              buf_q <= merged;
            end
          end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o = in_ready;
  assign busy_o         = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_FLUSH);
  assign done_o         = (state_q == S_DONE);
  assign err_o          = (state_q == S_ERR) || ((state_q == S_DONE) && ovf_q);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a table of complete loads plus hand-written
// sequences for start-while-busy, idle timeout and reset mid-load.
module tb_rom_loader;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       busy_o, done_o, err_o;
  logic [2:0] dbg_state_o;

  rom_loader_if bus ();

  rom_loader #(
    .BASE_ADDR  (32'h0000_0000),
    .ROM_DEPTH  (2),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .bus        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int idle_bad = 0;
  logic [67:0] exp_q[$];
  logic [67:0] act_q[$];

  // Capture every write as {addr, data, sel}; flag nonzero bus while idle.
  always @(negedge clk) begin
    if (bus.w_en_o) act_q.push_back({bus.w_addr_o, bus.w_data_o, bus.w_sel_o});
    else if ((bus.w_addr_o != 32'd0) || (bus.w_data_o != 32'd0) || (bus.w_sel_o != 4'd0))
      idle_bad++;
  end

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compare_writes(input string name);
    logic [67:0] a, e;
    check({name, "_wr_count"}, 68'(act_q.size()), 68'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check({name, "_wr"}, a, e);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // All tasks enter and leave on a negedge.
  task automatic pulse_start;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = b;
    while (!bus.in_ready_o && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: in_ready_o stayed 0, expected 1");
    end
    @(negedge clk);
  endtask

  task automatic send_header(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[i*8 +: 8]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] len;
    int          nb;
    logic [7:0]  b[12];
    int          nw;
    logic [67:0] w[3];
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int lat;
    act_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.nw; i++) exp_q.push_back(v.w[i]);
    pulse_start();
    send_header(v.len);
    for (int i = 0; i < v.nb; i++) send_byte(v.b[i]);
    bus.in_valid_i = 1'b0;
    lat = (v.len[1:0] != 2'd0) ? 1 : 0;
    if (lat == 1) begin
      check({v.name, "_flush_busy"}, 68'(busy_o), 68'(1'b1));
      check({v.name, "_flush_notdone"}, 68'(done_o), 68'(1'b0));
      @(negedge clk);
    end
    check({v.name, "_done"}, 68'(done_o), 68'(v.done));
    check({v.name, "_err"}, 68'(err_o), 68'(v.err));
    check({v.name, "_busy"}, 68'(busy_o), 68'(1'b0));
    repeat (3) @(negedge clk);
    check({v.name, "_done_sticky"}, 68'(done_o), 68'(v.done));
    compare_writes(v.name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{name: "len8", len: 32'd8, nb: 8,
                b: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00},
                nw: 2, w: '{{32'h0, 32'h44332211, 4'hF}, {32'h4, 32'h88776655, 4'hF}, 68'h0},
                done: 1'b1, err: 1'b0};
    vecs[1] = '{name: "len6", len: 32'd6, nb: 6,
                b: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                nw: 2, w: '{{32'h0, 32'h04030201, 4'hF}, {32'h4, 32'h00000605, 4'h3}, 68'h0},
                done: 1'b1, err: 1'b0};
    vecs[2] = '{name: "len0", len: 32'd0, nb: 0,
                b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                nw: 0, w: '{68'h0, 68'h0, 68'h0},
                done: 1'b1, err: 1'b0};
    vecs[3] = '{name: "ovf12", len: 32'd12, nb: 12,
                b: '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7, 8'ha8, 8'ha9, 8'haa, 8'hab},
                nw: 2, w: '{{32'h0, 32'ha3a2a1a0, 4'hF}, {32'h4, 32'ha7a6a5a4, 4'hF}, 68'h0},
                done: 1'b1, err: 1'b1};
    vecs[4] = '{name: "len3", len: 32'd3, nb: 3,
                b: '{8'hc1, 8'hc2, 8'hc3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                nw: 1, w: '{{32'h0, 32'h00c3c2c1, 4'h7}, 68'h0, 68'h0},
                done: 1'b1, err: 1'b0};

    rst = 1'b1;
    start_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_state", 68'(dbg_state_o), 68'(3'd0));
    check("rst_ready", 68'(bus.in_ready_o), 68'(1'b0));
    check("rst_wen", 68'(bus.w_en_o), 68'(1'b0));
    check("rst_busy_done_err", 68'({busy_o, done_o, err_o}), 68'(3'b000));
    rst = 1'b0;
    @(negedge clk);
    act_q.delete();

    // Table of complete loads; ovf12 precedes len3 so the overflow flag must clear.
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // start_i while busy is ignored: the load continues as payload, not a new header.
    act_q.delete();
    exp_q.delete();
    exp_q.push_back({32'h0, 32'h04030201, 4'hF});
    pulse_start();
    send_header(32'd4);
    send_byte(8'h01);
    send_byte(8'h02);
    bus.in_valid_i = 1'b0;
    pulse_start();
    check("busy_start_busy", 68'(busy_o), 68'(1'b1));
    send_byte(8'h03);
    send_byte(8'h04);
    bus.in_valid_i = 1'b0;
    check("busy_start_done", 68'(done_o), 68'(1'b1));
    @(negedge clk);
    compare_writes("busy_start");

    // Timeout: len=8, five bytes, then silence until the 16th idle edge.
    act_q.delete();
    exp_q.delete();
    exp_q.push_back({32'h0, 32'h44332211, 4'hF});
    pulse_start();
    send_header(32'd8);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("wr_timing", 68'(bus.w_en_o), 68'(1'b1));
    send_byte(8'h55);
    bus.in_valid_i = 1'b0;
    repeat (15) @(negedge clk);
    check("to_before_err", 68'(err_o), 68'(1'b0));
    check("to_before_busy", 68'(busy_o), 68'(1'b1));
    @(negedge clk);
    check("to_err", 68'(err_o), 68'(1'b1));
    check("to_busy", 68'(busy_o), 68'(1'b0));
    check("to_done", 68'(done_o), 68'(1'b0));
    repeat (4) @(negedge clk);
    check("to_err_sticky", 68'(err_o), 68'(1'b1));
    compare_writes("timeout");
    run_vec(vecs[0]);

    // Reset one cycle after the third payload byte, with the fourth byte offered.
    act_q.delete();
    exp_q.delete();
    pulse_start();
    send_header(32'd8);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    bus.in_data_i = 8'h04;
    rst = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check("rst_mid_state", 68'(dbg_state_o), 68'(3'd0));
    check("rst_mid_outs", 68'({bus.in_ready_o, bus.w_en_o, busy_o, done_o, err_o}), 68'(5'b0));
    check("rst_mid_bus", 68'({bus.w_addr_o, bus.w_data_o, bus.w_sel_o}), 68'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_idle", 68'(dbg_state_o), 68'(3'd0));
    compare_writes("rst_mid");

    check("idle_bus_zero", 68'(idle_bad), 68'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
